// File: rtl/program_counter_stack_if.sv
// Control strobes and status outputs of the program counter with return stack.
// The shared tri-state bus stays a plain inout port on the module itself.
interface program_counter_stack_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int SPW = $clog2(DEPTH + 1);

  logic             ie;
  logic             oe;
  logic             step;
  logic             call;
  logic             ret;
  logic             clr_err;
  logic [WIDTH-1:0] data;
  logic [SPW-1:0]   sp;
  logic             full;
  logic             empty;
  logic             ovf;
  logic             unf;

  // Sequencer side: issues strobes, observes PC and stack status
  modport master (
    output ie, oe, step, call, ret, clr_err,
    input  data, sp, full, empty, ovf, unf
  );

  // Program counter side: consumes strobes, publishes PC and stack status
  modport slave (
    input  ie, oe, step, call, ret, clr_err,
    output data, sp, full, empty, ovf, unf
  );
endinterface

// File: rtl/program_counter_stack.sv
// Program counter with jump, increment and CALL/RET through a LIFO return stack.
// All state changes on the falling clock edge; only the bus is combinational.
module program_counter_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  inout  wire  [WIDTH-1:0]        bus,
  program_counter_stack_if.slave  pif
);
  localparam int SPW = $clog2(DEPTH + 1);
  // Stack address width; at least one bit so DEPTH=1 still has a legal index
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int RAM = 1 << AW;

  logic [WIDTH-1:0] data_r;
  logic [SPW-1:0]   sp_r;
  logic             ovf_r;
  logic             unf_r;
  logic [WIDTH-1:0] stack_r [0:RAM-1];

  logic [WIDTH-1:0] data_s;
  logic [SPW-1:0]   sp_s;
  logic             ovf_s;
  logic             unf_s;
  logic             push_s;
  logic             full_s;
  logic             empty_s;
  logic [AW-1:0]    push_idx_s;
  logic [AW-1:0]    pop_idx_s;

  assign full_s     = (sp_r == SPW'(DEPTH));
  assign empty_s    = (sp_r == {SPW{1'b0}});
  // Push writes the first free slot; pop reads the most recent entry.
  // Truncation is safe: the push index is only used when sp < DEPTH and
  // the pop index only when sp > 0.
  assign push_idx_s = AW'(sp_r);
  assign pop_idx_s  = AW'(sp_r - SPW'(1));

  // Only the bus is combinational: drive PC while oe, otherwise release it
  assign bus = pif.oe ? data_r : {WIDTH{1'bz}};

  assign pif.data  = data_r;
  assign pif.sp    = sp_r;
  assign pif.full  = full_s;
  assign pif.empty = empty_s;
  assign pif.ovf   = ovf_r;
  assign pif.unf   = unf_r;

  // Next-state decode: one operation per cycle, call > ret > ie > step
  always_comb begin
    data_s = data_r;
    sp_s   = sp_r;
    ovf_s  = pif.clr_err ? 1'b0 : ovf_r;
    unf_s  = pif.clr_err ? 1'b0 : unf_r;
    push_s = 1'b0;
    if (pif.call) begin
      if (full_s) begin
        // Overflow: PC and stack untouched, error set wins over clear
        ovf_s = 1'b1;
      end else begin
        push_s = 1'b1;
        sp_s   = sp_r + SPW'(1);
        data_s = bus;
      end
    end else if (pif.ret) begin
      if (empty_s) begin
        unf_s = 1'b1;
      end else begin
        data_s = stack_r[pop_idx_s];
        sp_s   = sp_r - SPW'(1);
      end
    end else if (pif.ie) begin
      data_s = bus;
    end else if (pif.step) begin
      data_s = data_r + WIDTH'(1);
    end else begin
      data_s = data_r;
    end
  end

  // PC, stack pointer and sticky flags; reset overrides every strobe
  always_ff @(negedge clk) begin
    if (!rst) begin
      data_r <= {WIDTH{1'b0}};
      sp_r   <= {SPW{1'b0}};
      ovf_r  <= 1'b0;
      unf_r  <= 1'b0;
    end else begin
      data_r <= data_s;
      sp_r   <= sp_s;
      ovf_r  <= ovf_s;
      unf_r  <= unf_s;
    end
  end

  // Return-address RAM: captures the PC held at CALL time, never cleared
  always_ff @(negedge clk) begin
    if (rst && push_s) begin
      stack_r[push_idx_s] <= data_r;
    end
  end
endmodule
